// File: rtl/eq_window_queue.sv
// eq_window_queue: CH-channel circular sample ring that bursts the latest WINDOW samples, oldest first.
// Optional QUEUE_FLUSH_EN macro adds a synchronous flush input that empties the queue and aborts bursts.
module eq_window_queue #(
  parameter int DATA_W = 16,
  parameter int CH     = 2,
  parameter int DEPTH  = 1536,
  parameter int WINDOW = 1021
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 smpl_vld,
  input  logic [CH*DATA_W-1:0] smpl_in,
  input  logic                 out_rdy,
`ifdef QUEUE_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 out_vld,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(WINDOW + 1);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  WIN_P     = PTR_W'(WINDOW);
  localparam logic [PTR_W-1:0]  OFS_P     = PTR_W'(DEPTH - WINDOW);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_TRIG = FILL_W'(WINDOW);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(WINDOW);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  logic [CH*DATA_W-1:0] mem [DEPTH];

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FILL_W-1:0]   fill;
  logic [BEAT_W-1:0]   issued;
  logic                pend;

  logic                flush_i;
  logic                wr_en;
  logic [FILL_W-1:0]   fill_inc;
  logic                trigger;
  logic [PTR_W-1:0]    start_ptr;
  logic                load;
  logic                done;
  logic                take;

`ifdef QUEUE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A flushed sample is discarded; every other strobe is written, even mid-burst.
  assign wr_en    = smpl_vld && !flush_i;
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign trigger  = wr_en && (fill_inc >= FILL_TRIG);

  // Window start uses the pre-write pointer, so a same-cycle write belongs to the next burst.
  assign start_ptr = (wr_ptr >= WIN_P) ? wr_ptr - WIN_P : wr_ptr + OFS_P;

  assign load = (state == S_BURST) && (issued != BEAT_MAX) && (!out_vld || out_rdy);
  assign done = out_vld && out_rdy && out_last;
  assign take = pend && ((state == S_IDLE) || ((state == S_BURST) && done));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= smpl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= ptr_inc(wr_ptr);
      fill   <= fill_inc;
    end
  end

  // Burst sequencer plus output register; the register only reloads when empty or accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      pend      <= 1'b0;
      overrun   <= 1'b0;
      rd_ptr    <= '0;
      issued    <= '0;
      out_vld   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (flush_i) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      pend      <= 1'b0;
      overrun   <= 1'b0;
      rd_ptr    <= '0;
      issued    <= '0;
      out_vld   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (trigger) begin
        pend <= 1'b1;
        if (pend && !take) begin
          overrun <= 1'b1;
        end
      end else if (take) begin
        pend <= 1'b0;
      end

      if (load) begin
        out_vld   <= 1'b1;
        out_data  <= mem[rd_ptr];
        out_first <= (issued == '0);
        out_last  <= (issued == BEAT_MAX - 1'b1);
        rd_ptr    <= ptr_inc(rd_ptr);
        issued    <= issued + 1'b1;
      end else if (out_rdy) begin
        out_vld   <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pend) begin
            state  <= S_BURST;
            busy   <= 1'b1;
            rd_ptr <= start_ptr;
            issued <= '0;
          end
        end
        S_BURST: begin
          if (done) begin
            if (pend) begin
              rd_ptr <= start_ptr;
              issued <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_window_queue.sv
// tb_eq_window_queue: directed bench for eq_window_queue (DEPTH=8, WINDOW=4, CH=2) with a beat scoreboard.
// Sections guarded by QUEUE_FLUSH_EN exercise the flush input when the macro is defined.
module tb_eq_window_queue;

  localparam int DATA_W = 16;
  localparam int CH     = 2;
  localparam int DEPTH  = 8;
  localparam int WIN    = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 smpl_vld;
  logic [CH*DATA_W-1:0] smpl_in;
  logic                 out_rdy;
`ifdef QUEUE_FLUSH_EN
  logic                 flush;
`endif
  logic                 out_vld;
  logic [CH*DATA_W-1:0] out_data;
  logic                 out_first;
  logic                 out_last;
  logic                 busy;
  logic                 overrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic [CH*DATA_W-1:0] hist[$];
  logic [CH*DATA_W+1:0] sb[$];

  logic [CH*DATA_W+1:0] prev_beat;
  logic [CH*DATA_W+1:0] cur_beat;
  logic [CH*DATA_W+1:0] exp_beat;
  logic                 prev_stall = 1'b0;

  eq_window_queue #(
    .DATA_W(DATA_W),
    .CH    (CH),
    .DEPTH (DEPTH),
    .WINDOW(WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl_vld (smpl_vld),
    .smpl_in  (smpl_in),
    .out_rdy  (out_rdy),
`ifdef QUEUE_FLUSH_EN
    .flush    (flush),
`endif
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DATA_W-1:0] smp(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {16'hA000 + v, v};
  endfunction

  task automatic applyStimulus(input logic [CH*DATA_W-1:0] data);
    smpl_vld = 1'b1;
    smpl_in  = data;
    hist.push_back(data);
    tick();
    smpl_vld = 1'b0;
  endtask

  // Expected burst: the newest WIN written samples, oldest first.
  task automatic pushWindow();
    for (int j = 0; j < WIN; j++) begin
      sb.push_back({(j == 0), (j == WIN - 1), hist[hist.size() - WIN + j]});
    end
  endtask

  // Beat monitor: compares accepted beats to the scoreboard and checks hold under backpressure.
  always @(negedge clk) begin
    cur_beat = {out_first, out_last, out_data};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_stable", {out_vld, cur_beat}, {1'b1, prev_beat});
      end
      if (out_vld && out_rdy) begin
        exp_beat = (sb.size() != 0) ? sb.pop_front() : '1;
        checkOutput("beat", cur_beat, exp_beat);
      end
      prev_stall = out_vld && !out_rdy;
      prev_beat  = cur_beat;
    end
  end

  initial begin
    int busy_cycles;
    logic seen;

    rst_n    = 1'b0;
    smpl_vld = 1'b0;
    smpl_in  = '0;
    out_rdy  = 1'b1;
`ifdef QUEUE_FLUSH_EN
    flush    = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_out_vld", out_vld, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_flags", {out_first, out_last}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] fill threshold");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(smp(i));
      repeat (4) tick();
      checkOutput("no_burst_below_window", {busy, out_vld}, 0);
    end
    applyStimulus(smp(4));
    pushWindow();
    checkOutput("busy_not_yet", busy, 0);
    tick();
    checkOutput("busy_rise", busy, 1);
    checkOutput("vld_latency", out_vld, 0);
    tick();
    checkOutput("first_vld", out_vld, 1);
    checkOutput("first_flag", out_first, 1);
    checkOutput("first_data", out_data, smp(1));
    tick();
    tick();
    tick();
    checkOutput("last_flag", out_last, 1);
    checkOutput("busy_hold", busy, 1);
    tick();
    checkOutput("busy_fall", busy, 0);
    checkOutput("vld_fall", out_vld, 0);
    checkOutput("sb_drained_threshold", sb.size(), 0);

    $display("[TB] wrap");
    for (int i = 5; i <= 10; i++) begin
      applyStimulus(smp(i));
      pushWindow();
      repeat (9) tick();
    end
    checkOutput("sb_drained_wrap", sb.size(), 0);
    checkOutput("idle_after_wrap", busy, 0);

    $display("[TB] backpressure");
    applyStimulus(smp(11));
    pushWindow();
    busy_cycles = 0;
    for (int k = 1; k <= 12; k++) begin
      out_rdy = k[0];
      tick();
      if (busy) busy_cycles++;
    end
    out_rdy = 1'b1;
    tick();
    checkOutput("burst_cycles_backpressure", busy_cycles, 2 * WIN);
    checkOutput("sb_drained_backpressure", sb.size(), 0);

    $display("[TB] overrun");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    hist.delete();
    out_rdy = 1'b0;
    for (int i = 101; i <= 103; i++) begin
      applyStimulus(smp(i));
      tick();
    end
    applyStimulus(smp(104));
    pushWindow();
    repeat (3) tick();
    checkOutput("overrun_clear_first", overrun, 0);
    applyStimulus(smp(105));
    tick();
    checkOutput("overrun_one_pending", overrun, 0);
    applyStimulus(smp(106));
    checkOutput("overrun_set", overrun, 1);
    applyStimulus(smp(107));
    pushWindow();
    tick();
    out_rdy = 1'b1;
    repeat (16) tick();
    checkOutput("sb_drained_overrun", sb.size(), 0);
    checkOutput("idle_after_overrun", busy, 0);
    checkOutput("overrun_sticky", overrun, 1);

    $display("[TB] reset mid-burst");
    out_rdy = 1'b0;
    applyStimulus(smp(200));
    tick();
    tick();
    checkOutput("vld_before_reset", out_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_vld", out_vld, 0);
    checkOutput("reset_mid_busy", busy, 0);
    checkOutput("reset_mid_overrun", overrun, 0);
    tick();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(smp(300 + i));
      repeat (3) begin
        tick();
        seen = seen | busy | out_vld;
      end
    end
    checkOutput("no_burst_after_reset", seen, 0);

`ifdef QUEUE_FLUSH_EN
    $display("[TB] flush mid-burst");
    applyStimulus(smp(303));
    tick();
    checkOutput("busy_before_flush", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_vld", out_vld, 0);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_overrun", overrun, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(smp(400 + i));
      repeat (3) begin
        tick();
        seen = seen | busy | out_vld;
      end
    end
    checkOutput("no_burst_after_flush", seen, 0);
`endif

    repeat (2) tick();
    checkOutput("sb_empty_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_window_queue.md
# eq_window_queue

Parametrised circular sample queue for the equalizer filter path. Buffers CH channels of DATA_W-bit audio samples in a shared DEPTH-entry ring. After each new sample it bursts the most recent WINDOW samples per channel, oldest first, to the downstream FIR engine at clk rate under a valid/ready handshake. It succeeds the fixed-size single-channel high-frequency queue: depth, window, width and channel count are parameters, writes are synchronous strobes, readout supports backpressure, and trigger overruns are flagged.

## Interface
- DATA_W, 16: sample width per channel.
- CH, 2: channel count; all channels share pointers and burst timing.
- DEPTH, 1536: ring entries per channel; must satisfy DEPTH ≥ WINDOW+2.
- WINDOW, 1021: samples per burst; WINDOW ≥ 2.
- clk  in  1: clock clk.
- rst_n  in  1: reset rst_n, asynchronous, active-low.
- smpl_vld  in  1: single-cycle write strobe, synchronous to clk.
- smpl_in  in  CH*DATA_W: new samples; channel k occupies bits [k*DATA_W +: DATA_W].
- out_rdy  in  1: downstream accepts the current beat.
- out_vld  out  1: out_data is valid.
- out_data  out  CH*DATA_W: window sample, same channel packing as smpl_in.
- out_first  out  1: asserted with the first beat of a burst.
- out_last  out  1: asserted with beat WINDOW of a burst.
- busy  out  1: burst in progress.
- overrun  out  1: sticky; a trigger was lost.
- flush  in  1: present only with QUEUE_FLUSH_EN.

## Operation
- Write: on a clk edge with smpl_vld=1, write smpl_in to wr_ptr. wr_ptr then increments, wrapping from DEPTH-1 to 0. Writes always occur, including during bursts.
- fill counter: increments on each write and saturates at DEPTH. Width is $clog2(DEPTH+1).
- Trigger: a write that leaves fill ≥ WINDOW sets pend=1. Earlier writes produce no burst.
- States:
  - IDLE → BURST when pend=1. On entry, capture start = (wr_ptr − WINDOW) mod DEPTH using the current wr_ptr, and clear pend.
  - BURST → IDLE after beat WINDOW is accepted.
  - BURST → BURST (back-to-back) if pend=1 at that point.
- Pend and overrun: pend is one-deep. If a trigger occurs while pend=1, set overrun=1 and leave pend=1. overrun is cleared only by reset or flush.
- Readout:
  - rd_ptr starts at start and advances once per accepted beat, wrapping at DEPTH.
  - Memory read has 1-cycle latency.
  - An output register holds out_data, out_vld, out_first and out_last stable while out_vld=1 and out_rdy=0.
- Beats: beat count runs 1..WINDOW. out_first is set on beat 1 and out_last on beat WINDOW. Both are 0 whenever out_vld=0.
- Write/read collision: a write to the entry currently being read is impossible when DEPTH ≥ WINDOW+2 and at most one trigger is pending. No bypass logic.
- Reset values: out_vld, out_first, out_last, busy, overrun all 0; out_data 0. Internally wr_ptr, rd_ptr, fill and beat count are 0, pend is 0, state is IDLE.
- Reset mid-burst: the burst aborts immediately and the queue returns to empty. Memory contents are don't-care.

## Timing
- smpl_vld at edge n: the write completes at n. pend is visible at n+1. busy=1 from n+2. The first out_vld=1 is at n+3.
- With out_rdy held at 1: one beat per cycle; the burst lasts WINDOW cycles.
- busy falls on the cycle after the out_last beat is accepted, unless a back-to-back burst starts. A back-to-back burst keeps busy=1 with a 1-cycle out_vld gap.
- out_rdy=0: all outputs hold; rd_ptr does not advance.
- Simultaneous smpl_vld and burst start in the same cycle: start uses the pre-write wr_ptr. The new write sets pend for the next burst.

## Configuration
- QUEUE_FLUSH_EN defined:
  - Adds the flush input. flush=1 at an edge clears fill, pend and overrun, and sets wr_ptr=0.
  - It aborts any burst: next cycle state is IDLE and out_vld=0.
  - flush has priority over a simultaneous smpl_vld; that sample is discarded.
- QUEUE_FLUSH_EN undefined: the flush port does not exist; only rst_n empties the queue.

## Test plan
- Fill threshold, DEPTH=8, WINDOW=4, out_rdy=1: write 1,2,3 → no busy. Write 4 → busy rises, beats 1,2,3,4 with out_first on 1 and out_last on 4.
- Wrap, same params: write 1..10 spaced 10 cycles apart. The burst after 10 outputs 7,8,9,10. wr_ptr wraps to 2.
- Backpressure: toggle out_rdy every cycle during a burst → each beat is held stable until accepted, no beat is lost or duplicated, and the burst takes 2×WINDOW cycles.
- Overrun: DEPTH=8, WINDOW=4, out_rdy=0. Issue 3 triggering writes during one burst → overrun=1 and exactly 2 bursts are output.
- Channels CH=2: smpl_in = {16'hA000+i, 16'h0000+i} → out_data upper/lower halves track per channel in order.
- Reset/flush mid-burst (QUEUE_FLUSH_EN on) → out_vld=0 next cycle, busy=0, and 3 further writes produce no burst.
